// File: rtl/bram_march_tester.sv
// March-style self-test engine for the dual-port BRAM. It writes on port A, reads on port B,
// and reports pass/fail, the first failing address and data, and a saturating error count.
module bram_march_tester #(
  parameter int          P_DATA_WIDTH        = 16,
  parameter int          P_ADDRESS_WIDTH     = 10,
  parameter int          P_READ_LATENCY      = 1,
  parameter int          P_PATTERN_MODE      = 0,
  parameter logic [15:0] P_SEED              = 16'h5A5A,
  parameter int          P_ERROR_COUNT_WIDTH = 8
) (
  input  logic                           I_CLK,
  input  logic                           I_NRESET,
  input  logic                           I_START,
  input  logic                           I_STEP_MODE,
  input  logic                           I_STEP,
  output logic [P_ADDRESS_WIDTH-1:0]     O_BRAM_ADDRESS_A,
  output logic [P_DATA_WIDTH-1:0]        O_BRAM_DATA_A,
  output logic                           O_BRAM_WRITE_ENABLE_A,
  output logic [P_ADDRESS_WIDTH-1:0]     O_BRAM_ADDRESS_B,
  input  logic [P_DATA_WIDTH-1:0]        I_BRAM_DATA_B,
  output logic                           O_BUSY,
  output logic                           O_DONE,
  output logic                           O_PASS,
  output logic [2:0]                     O_PHASE,
  output logic [P_ERROR_COUNT_WIDTH-1:0] O_ERROR_COUNT,
  output logic [P_ADDRESS_WIDTH-1:0]     O_FAIL_ADDRESS,
  output logic [P_DATA_WIDTH-1:0]        O_FAIL_DATA
);

  localparam int AW  = P_ADDRESS_WIDTH;
  localparam int DW  = P_DATA_WIDTH;
  localparam int ECW = P_ERROR_COUNT_WIDTH;

  // Running states share their encoding with the O_PHASE code they display.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W0    = 3'd1;
  localparam logic [2:0] S_R0W1  = 3'd2;
  localparam logic [2:0] S_R1W0  = 3'd3;
  localparam logic [2:0] S_R0    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_PAUSE = 3'd6;

  localparam logic [1:0]     LAT       = 2'(P_READ_LATENCY);
  localparam logic [AW-1:0]  ADDR_LAST = '1;
  localparam logic [AW-1:0]  ADDR_ONE  = AW'(1);
  localparam logic [ECW-1:0] ERR_ONE   = ECW'(1);

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    p = '0;
    case (P_PATTERN_MODE)
      0: p = DW'(a);
      1: for (int i = 0; i < DW; i++) p[i] = i[0] ^ a[0];
      default: p = DW'(P_SEED);
    endcase
    return p;
  endfunction

  logic [2:0]     state;
  logic [2:0]     paused_phase;
  logic [AW-1:0]  addr;
  logic [1:0]     wait_cnt;
  logic [ECW-1:0] err_cnt;
  logic [AW-1:0]  fail_addr;
  logic [DW-1:0]  fail_data;
  logic           done_q;
  logic           start_q;
  logic           step_s1, step_s2, step_s3;

  logic          in_read, compare, at_terminal, phase_end, mismatch;
  logic          start_edge, step_edge;
  logic [DW-1:0] expected;

  assign start_edge  = I_START & ~start_q;
  assign step_edge   = step_s2 & ~step_s3;
  assign in_read     = (state == S_R0W1) || (state == S_R1W0) || (state == S_R0);
  assign compare     = in_read && (wait_cnt == LAT);
  assign at_terminal = (state == S_R1W0) ? (addr == '0) : (addr == ADDR_LAST);
  assign phase_end   = at_terminal && ((state == S_W0) || compare);
  assign expected    = (state == S_R1W0) ? ~pattern(addr) : pattern(addr);
  assign mismatch    = compare && (I_BRAM_DATA_B != expected);

  assign O_BRAM_ADDRESS_A      = addr;
  assign O_BRAM_ADDRESS_B      = addr;
  assign O_BRAM_WRITE_ENABLE_A = (state == S_W0) || (compare && (state != S_R0));
  assign O_BUSY        = (state != S_IDLE) && (state != S_DONE);
  assign O_DONE        = done_q;
  assign O_PASS        = (state == S_DONE) && (err_cnt == '0);
  assign O_PHASE       = (state == S_PAUSE) ? paused_phase : state;
  assign O_ERROR_COUNT = err_cnt;
  assign O_FAIL_ADDRESS = fail_addr;
  assign O_FAIL_DATA    = fail_data;

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    O_BRAM_DATA_A = '0;
    case (state)
      S_W0, S_R1W0: O_BRAM_DATA_A = pattern(addr);
      S_R0W1:       O_BRAM_DATA_A = ~pattern(addr);
      default:      O_BRAM_DATA_A = '0;
    endcase
  end

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state        <= S_IDLE;
      paused_phase <= S_IDLE;
      addr         <= '0;
      wait_cnt     <= '0;
      err_cnt      <= '0;
      fail_addr    <= '0;
      fail_data    <= '0;
      done_q       <= 1'b0;
      // A START level held through reset must not look like a fresh edge on release.
      start_q      <= 1'b1;
      step_s1      <= 1'b0;
      step_s2      <= 1'b0;
      step_s3      <= 1'b0;
    end else begin
      start_q <= I_START;
      step_s1 <= I_STEP;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
      done_q  <= 1'b0;

      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
        if (err_cnt == '0) begin
          fail_addr <= addr;
          fail_data <= I_BRAM_DATA_B;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            state     <= S_W0;
            addr      <= '0;
            wait_cnt  <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        S_W0, S_R0W1, S_R1W0, S_R0: begin
          if (in_read) wait_cnt <= compare ? 2'd0 : wait_cnt + 2'd1;
          if (phase_end) begin
            if (state == S_R0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              addr   <= '0;
            end else begin
              // Preload the next phase's start address so a pause resumes cleanly.
              addr <= (state == S_R0W1) ? ADDR_LAST : '0;
              if (I_STEP_MODE) begin
                state        <= S_PAUSE;
                paused_phase <= state;
              end else begin
                state <= state + 3'd1;
              end
            end
          end else if ((state == S_W0) || compare) begin
            addr <= (state == S_R1W0) ? addr - ADDR_ONE : addr + ADDR_ONE;
          end
        end
        S_PAUSE: begin
          if (step_edge) state <= paused_phase + 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_march_tester.md
Name: bram_march_tester

Overview:
Parametrised self-test engine for the dual-port `bram`. It replaces manual step-through checking with an automatic March-style sequence: fill, read/verify/invert ascending, read/verify/restore descending, final verify. Writes go out on port A and reads come in on port B. It reports pass/fail, the first failing address and data, and a saturating error count, for display on the 7-segment logic or for use by a bench. An optional step mode pauses between phases for on-board debugging.

Parameters:
P_DATA_WIDTH, 16, BRAM word width (≥4).
P_ADDRESS_WIDTH, 10, BRAM address width (≥1); depth D = 2^P_ADDRESS_WIDTH.
P_READ_LATENCY, 1, cycles from port-B address to valid I_BRAM_DATA_B (1..3).
P_PATTERN_MODE, 0, 0 = address-as-data (zero-extended/truncated to P_DATA_WIDTH); 1 = checkerboard (address LSB 0 → 0xAA.., 1 → 0x55..); 2 = constant P_SEED.
P_SEED, 16'h5A5A, constant pattern for mode 2 (truncated/extended to P_DATA_WIDTH).
P_ERROR_COUNT_WIDTH, 8, width of the error counter.

Ports:
I_CLK  input  1  system clock; all logic on the rising edge.
I_NRESET  input  1  asynchronous, active-low reset.
I_START  input  1  level; a rising edge, detected synchronously, starts a run when idle.
I_STEP_MODE  input  1  1 = pause between phases.
I_STEP  input  1  asynchronous button; 2-FF synchronised, rising-edge detected.
O_BRAM_ADDRESS_A  output  P_ADDRESS_WIDTH  write address.
O_BRAM_DATA_A  output  P_DATA_WIDTH  write data.
O_BRAM_WRITE_ENABLE_A  output  1  write strobe.
O_BRAM_ADDRESS_B  output  P_ADDRESS_WIDTH  read address.
I_BRAM_DATA_B  input  P_DATA_WIDTH  read data.
O_BUSY  output  1  run in progress, including paused.
O_DONE  output  1  one-cycle pulse at run end.
O_PASS  output  1  valid after O_DONE; high when the error count is 0.
O_PHASE  output  3  0 idle, 1 W0, 2 R0W1, 3 R1W0, 4 R0, 5 done.
O_ERROR_COUNT  output  P_ERROR_COUNT_WIDTH  mismatches; saturates at all-ones.
O_FAIL_ADDRESS  output  P_ADDRESS_WIDTH  address of the first mismatch.
O_FAIL_DATA  output  P_DATA_WIDTH  data read at the first mismatch.

Behaviour:
- Reset (asynchronous): go to IDLE. All outputs are 0, both address outputs are 0, the write enable is 0, and the fail registers and counter are cleared.
- IDLE: O_PHASE=0. A START edge clears the counter and fail registers and, on the next cycle, enters W0 with O_BUSY=1. START edges while busy are ignored.
- P(a) is the pattern for address a; ~P(a) is its bitwise inverse.
- W0: ascending a=0..D-1. Write P(a) with one write per cycle; D cycles.
- R0W1: ascending. Each address takes P_READ_LATENCY+1 cycles:
  - drive O_BRAM_ADDRESS_B=a;
  - wait P_READ_LATENCY cycles;
  - in the compare cycle, check I_BRAM_DATA_B against P(a) and, in the same cycle, write ~P(a) to address a on port A.
- R1W0: descending a=D-1..0. Same timing as R0W1; expect ~P(a), write P(a).
- R0: ascending. Read and expect P(a); no writes.
- Mismatch handling:
  - O_ERROR_COUNT increments, holding at all-ones once saturated.
  - On the first mismatch only, capture O_FAIL_ADDRESS and O_FAIL_DATA.
  - The write in that compare cycle still occurs.
- Address sequencing: a phase ends at its terminal address (D-1 ascending, 0 descending). The counter never wraps mid-phase.
- Step mode:
  - With I_STEP_MODE=1 at a phase boundary after W0, R0W1 or R1W0, enter PAUSE.
  - In PAUSE, O_PHASE shows the completed phase, O_BUSY stays 1 and the write enable is 0.
  - A STEP edge starts the next phase on the following cycle.
  - There is no pause after R0.
  - I_STEP_MODE is sampled only at phase boundaries.
- Completion:
  - After the R0 terminal compare, O_DONE pulses for 1 cycle, O_BUSY drops, and O_PHASE=5.
  - O_PASS and the fail registers hold until the next START or reset.
- Timing with step mode off: busy lasts D + 3·D·(P_READ_LATENCY+1) cycles.
- Write enable is never asserted outside W0, R0W1 and R1W0.
- Reset mid-run: abort immediately with no further writes. BRAM contents are unspecified afterwards.

Test Plan:
- Reset held 3 cycles with I_START=1 → all outputs 0 and no write enable; after release, no run starts until a fresh START edge.
- Fault-free BRAM model (AW=4, DW=16, latency 1, mode 0), START → O_BUSY high for exactly 112 cycles, then a 1-cycle O_DONE, O_PASS=1, O_ERROR_COUNT=0; final memory holds a at address a.
- Bit 0 stuck-at-0 at address 5, same config → O_PASS=0, O_ERROR_COUNT=2 (R0W1 and R0), O_FAIL_ADDRESS=5, O_FAIL_DATA=0x0004.
- Step mode on, fault-free, mode 1 → pauses with O_PHASE=1, 2, 3 in turn, each needing one STEP pulse; STEP while idle does nothing; O_PASS=1 at the end.
- Every cell stuck at 0x0000, P_ERROR_COUNT_WIDTH=2, mode 2 → O_ERROR_COUNT saturates at 3; first fail at address 0 in R0W1 with data 0x0000.
- START pulsed mid-R0W1 → ignored, cycle count unchanged; reset asserted mid-R1W0 → IDLE immediately and no write occurs after the reset edge.
